// File: rtl/padring_ctrl.sv
// padring_ctrl: direction/data controller for a ring of bidirectional pads.
// Inserts a break-before-make guard whenever any pad changes direction.
//
// Ports:
//   clk, rst           single rising-edge clock, synchronous active-high reset
//   cfg_valid/ready    request handshake; ready only while idle
//   cfg_dir, cfg_data  requested per-pad direction (1=out) and drive value
//   pad_oe/ie/a        PADBIDIR output enable, input enable, drive value
//   pad_y              PADBIDIR receive value (asynchronous to clk)
//   rd_data            synchronized pad_y masked by pad_ie
//   cur_dir            direction currently applied to the pads
//   busy               direction turnaround in progress
module padring_ctrl #(
    parameter int GPIO_WIDTH  = 15,
    parameter int TURN_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [GPIO_WIDTH-1:0] cfg_dir,
    input  logic [GPIO_WIDTH-1:0] cfg_data,
    output logic [GPIO_WIDTH-1:0] pad_oe,
    output logic [GPIO_WIDTH-1:0] pad_ie,
    output logic [GPIO_WIDTH-1:0] pad_a,
    input  logic [GPIO_WIDTH-1:0] pad_y,
    output logic [GPIO_WIDTH-1:0] rd_data,
    output logic [GPIO_WIDTH-1:0] cur_dir,
    output logic                  busy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] OFF  = 1'b1;

    logic [0:0]            state_q,    state_d;
    logic [7:0]            cnt_q,      cnt_d;
    logic [GPIO_WIDTH-1:0] cur_dir_q,  cur_dir_d;
    logic [GPIO_WIDTH-1:0] pend_dir_q, pend_dir_d;
    logic [GPIO_WIDTH-1:0] pad_oe_q,   pad_oe_d;
    logic [GPIO_WIDTH-1:0] pad_ie_q,   pad_ie_d;
    logic [GPIO_WIDTH-1:0] pad_a_q,    pad_a_d;
    logic [GPIO_WIDTH-1:0] sync1_q,    sync2_q;
    logic [GPIO_WIDTH-1:0] rd_data_q;
    logic [GPIO_WIDTH-1:0] chg;
    logic                  accept;

    assign cfg_ready = (state_q == IDLE);
    assign busy      = (state_q == OFF);
    assign accept    = cfg_valid && cfg_ready;
    assign chg       = cfg_dir ^ cur_dir_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_dir_d  = cur_dir_q;
        pend_dir_d = pend_dir_q;
        pad_oe_d   = pad_oe_q;
        pad_ie_d   = pad_ie_q;
        pad_a_d    = pad_a_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    pad_a_d = cfg_data;
                    if (chg != '0) begin
                        // Only changing pads are released; others keep
                        // driving or receiving through the guard.
                        pend_dir_d = cfg_dir;
                        pad_oe_d   = pad_oe_q & ~chg;
                        pad_ie_d   = pad_ie_q & ~chg;
                        cnt_d      = 8'(TURN_CYCLES - 1);
                        state_d    = OFF;
                    end
                end
            end
            default: begin
                if (cnt_q == 8'd0) begin
                    cur_dir_d = pend_dir_q;
                    pad_oe_d  = pend_dir_q;
                    pad_ie_d  = ~pend_dir_q;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cur_dir_q  <= '0;
            pend_dir_q <= '0;
            pad_oe_q   <= '0;
            pad_ie_q   <= '1;
            pad_a_q    <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_dir_q  <= cur_dir_d;
            pend_dir_q <= pend_dir_d;
            pad_oe_q   <= pad_oe_d;
            pad_ie_q   <= pad_ie_d;
            pad_a_q    <= pad_a_d;
            // Two-stage synchronizer for the asynchronous pad_y.
            sync1_q    <= pad_y;
            sync2_q    <= sync1_q;
            rd_data_q  <= sync2_q & pad_ie_q;
        end
    end

    assign pad_oe  = pad_oe_q;
    assign pad_ie  = pad_ie_q;
    assign pad_a   = pad_a_q;
    assign rd_data = rd_data_q;
    assign cur_dir = cur_dir_q;

endmodule

// File: tb/tb_padring_ctrl.sv
// tb_padring_ctrl: directed self-checking bench for padring_ctrl.
// Expected values are hand-computed for GPIO_WIDTH=15, TURN_CYCLES=4.
module tb_padring_ctrl;

    localparam int W = 15;
    localparam int T = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [W-1:0] cfg_dir = '0;
    logic [W-1:0] cfg_data = '0;
    logic [W-1:0] pad_oe, pad_ie, pad_a;
    logic [W-1:0] pad_y = '0;
    logic [W-1:0] rd_data, cur_dir;
    logic         busy;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    padring_ctrl #(.GPIO_WIDTH(W), .TURN_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_dir(cfg_dir), .cfg_data(cfg_data),
        .pad_oe(pad_oe), .pad_ie(pad_ie), .pad_a(pad_a),
        .pad_y(pad_y), .rd_data(rd_data),
        .cur_dir(cur_dir), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until the controller is ready again.
    task automatic wait_idle(input string tag);
        int n = 0;
        while (cfg_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(cfg_ready), 32'd1);
    endtask

    task automatic send(input logic [W-1:0] d, input logic [W-1:0] v);
        wait_idle("send_ready");
        cfg_dir   = d;
        cfg_data  = v;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (started) chk("oe_ie_excl", 32'(pad_oe & pad_ie), 32'd0);
    end

    initial begin
        // Reset then idle.
        tick(); tick();
        rst = 1'b0;
        started = 1'b1;
        chk("rst_oe", 32'(pad_oe), 32'h0000);
        chk("rst_ie", 32'(pad_ie), 32'h7FFF);
        chk("rst_a", 32'(pad_a), 32'h0000);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dir", 32'(cur_dir), 32'h0000);
        chk("rst_rd", 32'(rd_data), 32'h0000);

        // Turnaround 0 -> 0x000F; hold a second request during OFF.
        cfg_dir = 15'h000F; cfg_data = 15'h0005; cfg_valid = 1'b1;
        tick();
        cfg_dir = 15'h7000; cfg_data = 15'h1234;
        chk("t1_a", 32'(pad_a), 32'h0005);
        chk("t1_oe0", 32'(pad_oe), 32'h0000);
        chk("t1_ie0", 32'(pad_ie), 32'h7FF0);
        chk("t1_busy0", 32'(busy), 32'd1);
        chk("t1_rdy0", 32'(cfg_ready), 32'd0);
        for (int i = 1; i < T; i++) begin
            tick();
            chk("t1_busy", 32'(busy), 32'd1);
            chk("t1_rdy", 32'(cfg_ready), 32'd0);
            chk("t1_ie", 32'(pad_ie), 32'h7FF0);
            chk("t1_oe", 32'(pad_oe), 32'h0000);
            chk("t1_hold_a", 32'(pad_a), 32'h0005);
        end
        tick();
        chk("t1_oe_new", 32'(pad_oe), 32'h000F);
        chk("t1_ie_new", 32'(pad_ie), 32'h7FF0);
        chk("t1_dir", 32'(cur_dir), 32'h000F);
        chk("t1_ready", 32'(cfg_ready), 32'd1);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("ign_a", 32'(pad_a), 32'h0005);

        // Held request now accepted: bits 14:12 and 3:0 change.
        tick();
        cfg_valid = 1'b0;
        chk("t2_a", 32'(pad_a), 32'h1234);
        chk("t2_oe0", 32'(pad_oe), 32'h0000);
        chk("t2_ie0", 32'(pad_ie), 32'h0FF0);
        chk("t2_busy0", 32'(busy), 32'd1);
        for (int i = 1; i < T; i++) begin
            tick();
            chk("t2_busy", 32'(busy), 32'd1);
            chk("t2_ie", 32'(pad_ie), 32'h0FF0);
        end
        tick();
        chk("t2_oe_new", 32'(pad_oe), 32'h7000);
        chk("t2_ie_new", 32'(pad_ie), 32'h0FFF);
        chk("t2_dir", 32'(cur_dir), 32'h7000);

        // Back to 0x000F, then the input path.
        send(15'h000F, 15'h0005);
        wait_idle("t3_idle");
        chk("t3_ie", 32'(pad_ie), 32'h7FF0);
        pad_y = 15'h7FFF;
        tick(); tick();
        chk("rd_lat2", 32'(rd_data), 32'h0000);
        tick();
        chk("rd_lat3", 32'(rd_data), 32'h7FF0);
        pad_y = 15'h5555;
        tick(); tick(); tick();
        chk("rd_5555", 32'(rd_data), 32'h5550);

        // Data-only write with cur_dir = 0x00FF.
        send(15'h00FF, 15'h0000);
        wait_idle("t4_idle");
        chk("t4_dir", 32'(cur_dir), 32'h00FF);
        send(15'h00FF, 15'h00A5);
        chk("d_a", 32'(pad_a), 32'h00A5);
        chk("d_oe", 32'(pad_oe), 32'h00FF);
        chk("d_ie", 32'(pad_ie), 32'h7F00);
        chk("d_busy", 32'(busy), 32'd0);
        chk("d_ready", 32'(cfg_ready), 32'd1);
        tick();
        chk("d_busy2", 32'(busy), 32'd0);

        // Reset during the second OFF cycle; valid during rst ignored.
        cfg_dir = 15'h0000; cfg_data = 15'h0000; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("r_busy1", 32'(busy), 32'd1);
        tick();
        chk("r_busy2", 32'(busy), 32'd1);
        rst = 1'b1;
        cfg_valid = 1'b1; cfg_dir = 15'h0003; cfg_data = 15'h0003;
        tick();
        rst = 1'b0;
        cfg_valid = 1'b0;
        chk("r_oe", 32'(pad_oe), 32'h0000);
        chk("r_ie", 32'(pad_ie), 32'h7FFF);
        chk("r_dir", 32'(cur_dir), 32'h0000);
        chk("r_ready", 32'(cfg_ready), 32'd1);
        chk("r_busy", 32'(busy), 32'd0);
        chk("r_a", 32'(pad_a), 32'h0000);
        chk("r_rd", 32'(rd_data), 32'h0000);
        repeat (6) tick();
        chk("r_busy_after", 32'(busy), 32'd0);
        chk("r_dir_after", 32'(cur_dir), 32'h0000);
        chk("r_oe_after", 32'(pad_oe), 32'h0000);
        chk("r_ie_after", 32'(pad_ie), 32'h7FFF);

        started = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
